as5311_emu: RTL and testbench

AS5311_EMU -- requirements
Module: as5311_emu

---
 rtl/as5311_emu.sv | 153 +++++++++++++++
 tb/tb_as5311_emu.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/as5311_emu.sv
// AS5311-style SSI slave emulator: 18-bit {value, status, parity} frames over a resynchronised SSI link.
// Optional parity-error injection port is enabled by defining AS5311_EMU_PARITY_ERR_EN.
`timescale 1ns / 1ps

module as5311_emu #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          IDLE_DO     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ssi_clk,
    input  logic        ssi_cs,
    output logic        ssi_do,
    input  logic [11:0] pos_in,
    input  logic [11:0] mag_in,
    input  logic [4:0]  status_in,
`ifdef AS5311_EMU_PARITY_ERR_EN
    input  logic        inject_perr,
`endif
    output logic        frame_done,
    output logic        frame_abort,
    output logic        frame_mag,
    output logic        busy,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StOver  = 2'd2
    } state_e;

    state_e                 r_state, w_state_d;
    logic [SYNC_STAGES-1:0] r_clk_sync, r_cs_sync;
    logic                   r_clk_prev, r_cs_prev;
    logic [17:0]            r_frame, w_frame_d;
    logic [4:0]             r_cnt, w_cnt_d;
    logic                   r_do, w_do_d;
    logic                   r_done, w_done_d;
    logic                   r_abort, w_abort_d;
    logic                   r_mag, w_mag_d;
    logic [15:0]            r_count, w_count_d;

    logic        w_clk_s, w_cs_s;
    logic        w_clk_rise, w_cs_rise, w_cs_fall;
    logic        w_perr;
    logic [11:0] w_value;
    logic        w_par;

    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_clk_rise = w_clk_s & ~r_clk_prev;
    assign w_cs_rise  = w_cs_s & ~r_cs_prev;
    assign w_cs_fall  = ~w_cs_s & r_cs_prev;

`ifdef AS5311_EMU_PARITY_ERR_EN
    assign w_perr = inject_perr;
`else
    assign w_perr = 1'b0;
`endif

    // ssi_clk low at the chip-select fall selects a magnetic-field frame
    assign w_value = w_clk_s ? pos_in : mag_in;
    assign w_par   = (^{w_value, status_in}) ^ w_perr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_sync <= '1;
            r_cs_sync  <= '1;
            r_clk_prev <= 1'b1;
            r_cs_prev  <= 1'b1;
            r_state    <= StIdle;
            r_frame    <= '0;
            r_cnt      <= '0;
            r_do       <= IDLE_DO;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_mag      <= 1'b0;
            r_count    <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ssi_clk};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], ssi_cs};
            r_clk_prev <= w_clk_s;
            r_cs_prev  <= w_cs_s;
            r_state    <= w_state_d;
            r_frame    <= w_frame_d;
            r_cnt      <= w_cnt_d;
            r_do       <= w_do_d;
            r_done     <= w_done_d;
            r_abort    <= w_abort_d;
            r_mag      <= w_mag_d;
            r_count    <= w_count_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_frame_d = r_frame;
        w_cnt_d   = r_cnt;
        w_do_d    = r_do;
        w_done_d  = 1'b0;
        w_abort_d = 1'b0;
        w_mag_d   = r_mag;
        w_count_d = r_count;
        unique case (r_state)
            StIdle: begin
                if (w_cs_fall) begin
                    w_state_d = StShift;
                    w_frame_d = {w_value, status_in, w_par};
                    w_mag_d   = ~w_clk_s;
                    w_cnt_d   = '0;
                    w_do_d    = 1'b0;
                end
            end
            StShift: begin
                // chip-select rise wins over a coincident clock rise
                if (w_cs_rise) begin
                    w_abort_d = 1'b1;
                    w_do_d    = IDLE_DO;
                    w_state_d = StIdle;
                end else if (w_clk_rise) begin
                    w_do_d    = r_frame[17];
                    w_frame_d = {r_frame[16:0], 1'b0};
                    w_cnt_d   = r_cnt + 5'd1;
                    if (r_cnt == 5'd17) begin
                        w_state_d = StOver;
                    end
                end
            end
            StOver: begin
                if (w_cs_rise) begin
                    w_done_d  = 1'b1;
                    w_count_d = r_count + 16'd1;
                    w_do_d    = IDLE_DO;
                    w_state_d = StIdle;
                end else if (w_clk_rise) begin
                    w_do_d = 1'b0;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign ssi_do      = r_do;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;
    assign frame_mag   = r_mag;
    assign busy        = (r_state != StIdle);
    assign frame_count = r_count;

endmodule

// File: tb/tb_as5311_emu.sv
// Self-checking bench for as5311_emu: a behavioural SSI master reads frames and compares them
// against a frame model built from value, status and even parity.
`timescale 1ns / 1ps

module tb_as5311_emu;

    localparam bit IDLE = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ssi_clk;
    logic        ssi_cs;
    logic        ssi_do;
    logic [11:0] pos_in;
    logic [11:0] mag_in;
    logic [4:0]  status_in;
    logic        frame_done;
    logic        frame_abort;
    logic        frame_mag;
    logic        busy;
    logic [15:0] frame_count;
    logic        perr_flag = 1'b0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          n_abort  = 0;
    logic [15:0] exp_count;

    as5311_emu #(
        .SYNC_STAGES (2),
        .IDLE_DO     (IDLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ssi_clk     (ssi_clk),
        .ssi_cs      (ssi_cs),
        .ssi_do      (ssi_do),
        .pos_in      (pos_in),
        .mag_in      (mag_in),
        .status_in   (status_in),
`ifdef AS5311_EMU_PARITY_ERR_EN
        .inject_perr (perr_flag),
`endif
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .frame_mag   (frame_mag),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (frame_abort) n_abort++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame as the master should see it: value, status, then bit making total parity even
    function automatic logic [17:0] ref_frame(input logic [11:0] v, input logic [4:0] st,
                                              input logic perr);
        int   ones;
        logic p;
        ones = $countones({v, st});
        p = ((ones % 2) != 0) ^ perr;
        return {v, st, p};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural master: one sample before the first rise (dummy) then one per high phase
    task automatic run_frame(input bit start_high, input int div, input int rises,
                             input int change_at, input logic [11:0] new_val,
                             input bit raise_cs, output logic [17:0] word, output logic dummy);
        ssi_clk = start_high;
        wait_cycles(div + 2);
        ssi_cs = 1'b0;
        wait_cycles(div + 2);
        dummy = ssi_do;
        word  = '0;
        for (int k = 1; k <= rises; k++) begin
            ssi_clk = 1'b0;
            wait_cycles(div);
            ssi_clk = 1'b1;
            wait_cycles(div);
            word = {word[16:0], ssi_do};
            if (k == change_at) begin
                pos_in    = new_val;
                mag_in    = ~new_val;
                status_in = ~status_in;
            end
        end
        if (raise_cs) begin
            ssi_cs = 1'b1;
            wait_cycles(div + 2);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ssi_clk   = 1'b1;
        ssi_cs    = 1'b1;
        pos_in    = '0;
        mag_in    = '0;
        status_in = '0;
        wait_cycles(5);
        n_checks++; if (ssi_do !== IDLE) begin n_fail++;
            $display("FAIL reset_do: got %b want %b", ssi_do, IDLE); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++;
            $display("FAIL reset_done: got %b want 0", frame_done); end
        n_checks++; if (frame_abort !== 1'b0) begin n_fail++;
            $display("FAIL reset_abort: got %b want 0", frame_abort); end
        n_checks++; if (frame_mag !== 1'b0) begin n_fail++;
            $display("FAIL reset_mag: got %b want 0", frame_mag); end
        n_checks++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_count !== 16'h0000) begin n_fail++;
            $display("FAIL reset_count: got %h want 0000", frame_count); end
        rst_n = 1'b1;
        exp_count = 16'h0000;
        wait_cycles(4);
    endtask

    task automatic test_pos_frame();
        logic [17:0] word;
        logic        dummy;
        int          d0;
        d0        = n_done;
        pos_in    = 12'hA5C;
        mag_in    = 12'h3C3;
        status_in = 5'b00000;
        run_frame(1'b1, 4, 18, 0, 12'h000, 1'b1, word, dummy);
        exp_count++;
        n_checks++; if (dummy !== 1'b0) begin n_fail++;
            $display("FAIL pos_dummy: got %b want 0", dummy); end
        n_checks++; if (word !== 18'h29700) begin n_fail++;
            $display("FAIL pos_word: got %h want 29700", word); end
        n_checks++; if (n_done !== d0 + 1) begin n_fail++;
            $display("FAIL pos_done_pulses: got %0d want %0d", n_done - d0, 1); end
        n_checks++; if (frame_count !== exp_count) begin n_fail++;
            $display("FAIL pos_count: got %h want %h", frame_count, exp_count); end
        n_checks++; if (frame_mag !== 1'b0) begin n_fail++;
            $display("FAIL pos_mag: got %b want 0", frame_mag); end
        n_checks++; if (busy !== 1'b0 || ssi_do !== IDLE) begin n_fail++;
            $display("FAIL pos_idle: got busy=%b do=%b want busy=0 do=%b", busy, ssi_do, IDLE); end
    endtask

    task automatic test_mag_frame();
        logic [17:0] word;
        logic        dummy;
        pos_in    = 12'hFFF;
        mag_in    = 12'h001;
        status_in = 5'b10000;
        run_frame(1'b0, 4, 18, 0, 12'h000, 1'b1, word, dummy);
        exp_count++;
        n_checks++; if (word !== 18'h00060) begin n_fail++;
            $display("FAIL mag_word: got %h want 00060", word); end
        n_checks++; if (frame_mag !== 1'b1) begin n_fail++;
            $display("FAIL mag_type: got %b want 1", frame_mag); end
        n_checks++; if (frame_count !== exp_count) begin n_fail++;
            $display("FAIL mag_count: got %h want %h", frame_count, exp_count); end
    endtask

    task automatic test_hold_inputs();
        logic [17:0] word;
        logic        dummy;
        pos_in    = 12'hA5C;
        status_in = 5'b00000;
        run_frame(1'b1, 4, 18, 3, 12'h123, 1'b1, word, dummy);
        exp_count++;
        n_checks++; if (word !== 18'h29700) begin n_fail++;
            $display("FAIL hold_word: got %h want 29700", word); end
    endtask

    task automatic test_abort();
        logic [17:0] word;
        logic        dummy;
        int          a0, d0;
        a0        = n_abort;
        d0        = n_done;
        pos_in    = 12'h5A5;
        status_in = 5'b01010;
        run_frame(1'b1, 4, 10, 0, 12'h000, 1'b0, word, dummy);
        n_checks++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL abort_busy_mid: got %b want 1", busy); end
        n_checks++; if (word[9:0] !== ref_frame(12'h5A5, 5'b01010, 1'b0) >> 8) begin n_fail++;
            $display("FAIL abort_partial: got %h want %h", word[9:0],
                     ref_frame(12'h5A5, 5'b01010, 1'b0) >> 8); end
        ssi_cs = 1'b1;
        wait_cycles(8);
        n_checks++; if (n_abort !== a0 + 1) begin n_fail++;
            $display("FAIL abort_pulses: got %0d want 1", n_abort - a0); end
        n_checks++; if (n_done !== d0) begin n_fail++;
            $display("FAIL abort_no_done: got %0d want 0", n_done - d0); end
        n_checks++; if (frame_count !== exp_count) begin n_fail++;
            $display("FAIL abort_count: got %h want %h", frame_count, exp_count); end
        n_checks++; if (ssi_do !== IDLE || busy !== 1'b0) begin n_fail++;
            $display("FAIL abort_idle: got do=%b busy=%b want do=%b busy=0", ssi_do, busy, IDLE); end
    endtask

    task automatic test_overrun();
        logic [17:0] word;
        logic [17:0] exp;
        logic        dummy;
        pos_in    = 12'h9E7;
        status_in = 5'b00111;
        run_frame(1'b1, 5, 20, 0, 12'h000, 1'b1, word, dummy);
        exp_count++;
        exp = ref_frame(12'h9E7, 5'b00111, 1'b0);
        exp = {exp[15:0], 2'b00};
        n_checks++; if (word !== exp) begin n_fail++;
            $display("FAIL overrun_word: got %h want %h", word, exp); end
        n_checks++; if (frame_count !== exp_count) begin n_fail++;
            $display("FAIL overrun_count: got %h want %h", frame_count, exp_count); end
    endtask

    task automatic test_random();
        logic [17:0] word;
        logic [17:0] exp;
        logic        dummy;
        logic [11:0] p, m;
        logic [4:0]  s;
        bit          hi;
        int          div;
        for (int i = 0; i < 16; i++) begin
            p   = 12'($urandom);
            m   = 12'($urandom);
            s   = 5'($urandom);
            hi  = 1'($urandom);
            div = int'($urandom_range(7, 4));
`ifdef AS5311_EMU_PARITY_ERR_EN
            perr_flag = 1'($urandom);
`endif
            pos_in    = p;
            mag_in    = m;
            status_in = s;
            run_frame(hi, div, 18, int'($urandom_range(17, 1)), 12'($urandom), 1'b1, word, dummy);
            exp_count++;
            exp = ref_frame(hi ? p : m, s, perr_flag);
            n_checks++; if (word !== exp) begin n_fail++;
                $display("FAIL rand_word[%0d]: got %h want %h", i, word, exp); end
            n_checks++; if (frame_mag !== !hi) begin n_fail++;
                $display("FAIL rand_mag[%0d]: got %b want %b", i, frame_mag, !hi); end
            n_checks++; if (frame_count !== exp_count) begin n_fail++;
                $display("FAIL rand_count[%0d]: got %h want %h", i, frame_count, exp_count); end
        end
        perr_flag = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [17:0] word;
        logic        dummy;
        int          a0;
        a0     = n_abort;
        pos_in = 12'h777;
        run_frame(1'b1, 4, 5, 0, 12'h000, 1'b0, word, dummy);
        rst_n  = 1'b0;
        ssi_cs = 1'b1;
        wait_cycles(3);
        rst_n  = 1'b1;
        exp_count = 16'h0000;
        wait_cycles(6);
        n_checks++; if (n_abort !== a0) begin n_fail++;
            $display("FAIL rstmid_abort: got %0d want 0", n_abort - a0); end
        n_checks++; if (busy !== 1'b0 || ssi_do !== IDLE) begin n_fail++;
            $display("FAIL rstmid_idle: got busy=%b do=%b want busy=0 do=%b", busy, ssi_do, IDLE); end
        n_checks++; if (frame_count !== exp_count) begin n_fail++;
            $display("FAIL rstmid_count: got %h want %h", frame_count, exp_count); end
        pos_in    = 12'h0F0;
        status_in = 5'b00001;
        run_frame(1'b1, 4, 18, 0, 12'h000, 1'b1, word, dummy);
        exp_count++;
        n_checks++; if (word !== ref_frame(12'h0F0, 5'b00001, 1'b0)) begin n_fail++;
            $display("FAIL rstmid_next_word: got %h want %h", word,
                     ref_frame(12'h0F0, 5'b00001, 1'b0)); end
    endtask

    task automatic test_count_wrap();
        logic [17:0] word;
        logic        dummy;
        // Preset stands in for 65535 prior frames
        @(negedge clk);
        force dut.r_count = 16'hFFFF;
        wait_cycles(2);
        release dut.r_count;
        wait_cycles(2);
        exp_count = 16'hFFFF;
        n_checks++; if (frame_count !== exp_count) begin n_fail++;
            $display("FAIL wrap_preset: got %h want %h", frame_count, exp_count); end
        pos_in    = 12'h321;
        status_in = 5'b00100;
        run_frame(1'b1, 4, 18, 0, 12'h000, 1'b1, word, dummy);
        exp_count++;
        n_checks++; if (frame_count !== 16'h0000) begin n_fail++;
            $display("FAIL wrap_count: got %h want 0000", frame_count); end
    endtask

`ifdef AS5311_EMU_PARITY_ERR_EN
    task automatic test_perr();
        logic [17:0] word;
        logic        dummy;
        pos_in    = 12'hA5C;
        status_in = 5'b00000;
        perr_flag = 1'b1;
        run_frame(1'b1, 4, 18, 0, 12'h000, 1'b1, word, dummy);
        perr_flag = 1'b0;
        exp_count++;
        n_checks++; if (word !== 18'h29701) begin n_fail++;
            $display("FAIL perr_word: got %h want 29701", word); end
    endtask
`endif

    initial begin
        test_reset();
        test_pos_frame();
        test_mag_frame();
        test_hold_inputs();
        test_abort();
        test_overrun();
        test_random();
        test_reset_midframe();
        test_count_wrap();
`ifdef AS5311_EMU_PARITY_ERR_EN
        test_perr();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
